// File: rtl/ray_slot_scheduler.sv
// ray_slot_scheduler
//
// Holds NUM_SLOTS independent DDA ray contexts. PEND slots are offered
// round-robin to the shared step pipeline, and tagged returns come back in any
// order. Each return either terminates its ray (solid hit, out of bounds or
// step limit) or loads the stepped position for another issue. Finished rays
// drain, lowest slot first, through a registered valid/ready result port.
//
// Ports:
//   clock, reset_n           sole clock (rising edge), async active-low reset
//   job_*                    new ray: start voxel, timers, step limit, tag
//   issue_*                  slot presented to the pipeline (valid/ready)
//   ret_*                    tagged pipeline return (solid/oob/next voxel/face)
//   res_*                    finished ray result (valid/ready, registered)
//   busy_count               number of slots that are not FREE
//   protocol_error           sticky flag: a return arrived for a slot not in WAIT
module ray_slot_scheduler #(
  parameter int X_BITS           = 5,
  parameter int Y_BITS           = 5,
  parameter int Z_BITS           = 5,
  parameter int TIMER_WIDTH      = 32,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int NUM_SLOTS        = 4,
  parameter int TAG_BITS         = 8,
  parameter int SLOT_BITS        = $clog2(NUM_SLOTS)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [X_BITS-1:0]           job_x,
  input  logic [Y_BITS-1:0]           job_y,
  input  logic [Z_BITS-1:0]           job_z,
  input  logic [TIMER_WIDTH-1:0]      job_timer_x,
  input  logic [TIMER_WIDTH-1:0]      job_timer_y,
  input  logic [TIMER_WIDTH-1:0]      job_timer_z,
  input  logic [STEP_COUNT_WIDTH-1:0] job_max_steps,
  input  logic [TAG_BITS-1:0]         job_tag,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [SLOT_BITS-1:0]        issue_slot,
  output logic [X_BITS-1:0]           issue_x,
  output logic [Y_BITS-1:0]           issue_y,
  output logic [Z_BITS-1:0]           issue_z,
  output logic [TIMER_WIDTH-1:0]      issue_timer_x,
  output logic [TIMER_WIDTH-1:0]      issue_timer_y,
  output logic [TIMER_WIDTH-1:0]      issue_timer_z,
  input  logic                        ret_valid,
  input  logic [SLOT_BITS-1:0]        ret_slot,
  input  logic                        ret_solid,
  input  logic                        ret_oob,
  input  logic [X_BITS-1:0]           ret_next_x,
  input  logic [Y_BITS-1:0]           ret_next_y,
  input  logic [Z_BITS-1:0]           ret_next_z,
  input  logic [TIMER_WIDTH-1:0]      ret_next_timer_x,
  input  logic [TIMER_WIDTH-1:0]      ret_next_timer_y,
  input  logic [TIMER_WIDTH-1:0]      ret_next_timer_z,
  input  logic [2:0]                  ret_face,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [TAG_BITS-1:0]         res_tag,
  output logic                        res_hit,
  output logic                        res_oob,
  output logic                        res_timeout,
  output logic [X_BITS-1:0]           res_x,
  output logic [Y_BITS-1:0]           res_y,
  output logic [Z_BITS-1:0]           res_z,
  output logic [2:0]                  res_face,
  output logic [STEP_COUNT_WIDTH-1:0] res_steps,
  output logic [SLOT_BITS:0]          busy_count,
  output logic                        protocol_error
);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PEND,
    SLOT_WAIT,
    SLOT_DONE
  } slot_state_t;

  slot_state_t                 state_q     [NUM_SLOTS];
  slot_state_t                 state_d     [NUM_SLOTS];
  logic [X_BITS-1:0]           slot_x      [NUM_SLOTS];
  logic [Y_BITS-1:0]           slot_y      [NUM_SLOTS];
  logic [Z_BITS-1:0]           slot_z      [NUM_SLOTS];
  logic [TIMER_WIDTH-1:0]      slot_tx     [NUM_SLOTS];
  logic [TIMER_WIDTH-1:0]      slot_ty     [NUM_SLOTS];
  logic [TIMER_WIDTH-1:0]      slot_tz     [NUM_SLOTS];
  logic [STEP_COUNT_WIDTH-1:0] slot_max    [NUM_SLOTS];
  logic [STEP_COUNT_WIDTH-1:0] slot_steps  [NUM_SLOTS];
  logic [TAG_BITS-1:0]         slot_tag    [NUM_SLOTS];
  logic [2:0]                  slot_face   [NUM_SLOTS];
  // Termination cause, {timeout, oob, hit}; only meaningful in DONE.
  logic [2:0]                  slot_cause  [NUM_SLOTS];

  logic [SLOT_BITS-1:0] rr_ptr;
  logic [SLOT_BITS-1:0] rr_cand;
  logic                 free_found;
  logic [SLOT_BITS-1:0] free_idx;
  logic                 done_found;
  logic [SLOT_BITS-1:0] done_idx;
  logic                 pend_found;
  logic [SLOT_BITS-1:0] pend_idx;

  logic accept;
  logic issue_fire;
  logic ret_ok;
  logic ret_steps_done;
  logic ret_terminate;
  logic res_load;

  // Lowest FREE and DONE slots, plus the first PEND slot at or after rr_ptr.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    done_found = 1'b0;
    done_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    rr_cand    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && state_q[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = SLOT_BITS'(i);
      end
      if (!done_found && state_q[i] == SLOT_DONE) begin
        done_found = 1'b1;
        done_idx   = SLOT_BITS'(i);
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rr_cand = rr_ptr + SLOT_BITS'(i);
      if (!pend_found && state_q[rr_cand] == SLOT_PEND) begin
        pend_found = 1'b1;
        pend_idx   = rr_cand;
      end
    end
  end

  assign job_ready      = free_found;
  assign issue_valid    = pend_found;
  assign issue_slot     = pend_idx;
  assign issue_x        = slot_x[pend_idx];
  assign issue_y        = slot_y[pend_idx];
  assign issue_z        = slot_z[pend_idx];
  assign issue_timer_x  = slot_tx[pend_idx];
  assign issue_timer_y  = slot_ty[pend_idx];
  assign issue_timer_z  = slot_tz[pend_idx];

  assign accept         = job_valid && free_found;
  assign issue_fire     = pend_found && issue_ready;
  assign ret_ok         = ret_valid && (state_q[ret_slot] == SLOT_WAIT);
  assign ret_steps_done = slot_steps[ret_slot] >= slot_max[ret_slot];
  assign ret_terminate  = ret_solid || ret_oob || ret_steps_done;
  // The result register refills in the same edge that hands its content out.
  assign res_load       = done_found && (!res_valid || res_ready);

  // Each event targets a slot in a different state, so they never collide.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
    end
    if (accept) begin
      state_d[free_idx] = SLOT_PEND;
    end
    if (issue_fire) begin
      state_d[pend_idx] = SLOT_WAIT;
    end
    if (ret_ok) begin
      state_d[ret_slot] = ret_terminate ? SLOT_DONE : SLOT_PEND;
    end
    if (res_load) begin
      state_d[done_idx] = SLOT_FREE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= SLOT_FREE;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Per-slot ray context: loaded on accept, advanced or frozen on return.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_x[i]     <= '0;
        slot_y[i]     <= '0;
        slot_z[i]     <= '0;
        slot_tx[i]    <= '0;
        slot_ty[i]    <= '0;
        slot_tz[i]    <= '0;
        slot_max[i]   <= '0;
        slot_steps[i] <= '0;
        slot_tag[i]   <= '0;
        slot_face[i]  <= '0;
        slot_cause[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (accept && free_idx == SLOT_BITS'(i)) begin
          slot_x[i]     <= job_x;
          slot_y[i]     <= job_y;
          slot_z[i]     <= job_z;
          slot_tx[i]    <= job_timer_x;
          slot_ty[i]    <= job_timer_y;
          slot_tz[i]    <= job_timer_z;
          slot_max[i]   <= job_max_steps;
          slot_steps[i] <= '0;
          slot_tag[i]   <= job_tag;
          slot_face[i]  <= '0;
          slot_cause[i] <= '0;
        end else if (ret_ok && ret_slot == SLOT_BITS'(i)) begin
          if (ret_solid) begin
            slot_cause[i] <= 3'b001;
          end else if (ret_oob) begin
            slot_cause[i] <= 3'b010;
          end else if (ret_steps_done) begin
            slot_cause[i] <= 3'b100;
          end else begin
            slot_x[i]    <= ret_next_x;
            slot_y[i]    <= ret_next_y;
            slot_z[i]    <= ret_next_z;
            slot_tx[i]   <= ret_next_timer_x;
            slot_ty[i]   <= ret_next_timer_y;
            slot_tz[i]   <= ret_next_timer_z;
            slot_face[i] <= ret_face;
            // Saturate rather than wrap so a huge limit cannot alias to zero.
            if (slot_steps[i] != '1) begin
              slot_steps[i] <= slot_steps[i] + STEP_COUNT_WIDTH'(1);
            end
          end
        end
      end
    end
  end

  // Round-robin pointer, sticky protocol flag and the result register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr         <= '0;
      protocol_error <= 1'b0;
      res_valid      <= 1'b0;
      res_tag        <= '0;
      res_hit        <= 1'b0;
      res_oob        <= 1'b0;
      res_timeout    <= 1'b0;
      res_x          <= '0;
      res_y          <= '0;
      res_z          <= '0;
      res_face       <= '0;
      res_steps      <= '0;
    end else begin
      if (issue_fire) begin
        rr_ptr <= pend_idx + SLOT_BITS'(1);
      end
      if (ret_valid && !ret_ok) begin
        protocol_error <= 1'b1;
      end
      if (res_load) begin
        res_valid   <= 1'b1;
        res_tag     <= slot_tag[done_idx];
        res_hit     <= slot_cause[done_idx][0];
        res_oob     <= slot_cause[done_idx][1];
        res_timeout <= slot_cause[done_idx][2];
        res_x       <= slot_x[done_idx];
        res_y       <= slot_y[done_idx];
        res_z       <= slot_z[done_idx];
        res_face    <= slot_face[done_idx];
        res_steps   <= slot_steps[done_idx];
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] != SLOT_FREE) begin
        busy_count = busy_count + (SLOT_BITS + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_ray_slot_scheduler.sv
// tb_ray_slot_scheduler
//
// Self-checking bench for ray_slot_scheduler. The bench plays the step
// pipeline: it tracks each slot's ray in a small model, pushes the expected
// result onto a scoreboard whenever it drives a terminating return, and pops
// and compares whenever the DUT hands a result out.
module tb_ray_slot_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        job_valid;
  logic        job_ready;
  logic [4:0]  job_x, job_y, job_z;
  logic [31:0] job_timer_x, job_timer_y, job_timer_z;
  logic [15:0] job_max_steps;
  logic [7:0]  job_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_slot;
  logic [4:0]  issue_x, issue_y, issue_z;
  logic [31:0] issue_timer_x, issue_timer_y, issue_timer_z;
  logic        ret_valid;
  logic [1:0]  ret_slot;
  logic        ret_solid, ret_oob;
  logic [4:0]  ret_next_x, ret_next_y, ret_next_z;
  logic [31:0] ret_next_timer_x, ret_next_timer_y, ret_next_timer_z;
  logic [2:0]  ret_face;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_tag;
  logic        res_hit, res_oob, res_timeout;
  logic [4:0]  res_x, res_y, res_z;
  logic [2:0]  res_face;
  logic [15:0] res_steps;
  logic [2:0]  busy_count;
  logic        protocol_error;

  int vectors     = 0;
  int miscompares = 0;
  int nexp;
  logic [63:0] snap;
  logic [63:0] exp_q [$];

  logic [4:0]  m_x     [4];
  logic [4:0]  m_y     [4];
  logic [4:0]  m_z     [4];
  logic [31:0] m_tx    [4];
  logic [31:0] m_ty    [4];
  logic [31:0] m_tz    [4];
  logic [15:0] m_max   [4];
  logic [15:0] m_steps [4];
  logic [7:0]  m_tag   [4];
  logic [2:0]  m_face  [4];

  ray_slot_scheduler dut (
    .clock(clock), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_z(job_z),
    .job_timer_x(job_timer_x), .job_timer_y(job_timer_y), .job_timer_z(job_timer_z),
    .job_max_steps(job_max_steps), .job_tag(job_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_slot(issue_slot),
    .issue_x(issue_x), .issue_y(issue_y), .issue_z(issue_z),
    .issue_timer_x(issue_timer_x), .issue_timer_y(issue_timer_y), .issue_timer_z(issue_timer_z),
    .ret_valid(ret_valid), .ret_slot(ret_slot), .ret_solid(ret_solid), .ret_oob(ret_oob),
    .ret_next_x(ret_next_x), .ret_next_y(ret_next_y), .ret_next_z(ret_next_z),
    .ret_next_timer_x(ret_next_timer_x), .ret_next_timer_y(ret_next_timer_y),
    .ret_next_timer_z(ret_next_timer_z), .ret_face(ret_face),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_hit(res_hit), .res_oob(res_oob), .res_timeout(res_timeout),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_face(res_face),
    .res_steps(res_steps), .busy_count(busy_count), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [63:0] pack_res(logic [7:0] tag, logic h, logic o, logic t,
                                           logic [4:0] x, logic [4:0] y, logic [4:0] z,
                                           logic [2:0] f, logic [15:0] s);
    return {19'd0, tag, h, o, t, x, y, z, f, s};
  endfunction

  function automatic logic [63:0] dut_res();
    return pack_res(res_tag, res_hit, res_oob, res_timeout, res_x, res_y, res_z,
                    res_face, res_steps);
  endfunction

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock: called at a falling edge, samples the result handshake just
  // before the rising edge and returns at the next falling edge.
  task automatic tick();
    logic [63:0] e;
    #2;
    if (res_valid && res_ready) begin
      check_output("sb_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("result", dut_res(), e);
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
  endtask

  task automatic apply_stimulus(input int slot, input logic [4:0] x, input logic [4:0] y,
                                input logic [4:0] z, input logic [15:0] mx,
                                input logic [7:0] tag);
    check_output("job_ready", job_ready, 1'b1);
    job_valid     = 1'b1;
    job_x         = x;
    job_y         = y;
    job_z         = z;
    job_timer_x   = 32'h1000 + 32'(tag);
    job_timer_y   = 32'h2000 + 32'(tag);
    job_timer_z   = 32'h3000 + 32'(tag);
    job_max_steps = mx;
    job_tag       = tag;
    m_x[slot] = x;  m_y[slot] = y;  m_z[slot] = z;
    m_tx[slot] = job_timer_x;  m_ty[slot] = job_timer_y;  m_tz[slot] = job_timer_z;
    m_max[slot] = mx;  m_steps[slot] = '0;  m_tag[slot] = tag;  m_face[slot] = '0;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_issue(input int slot);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (issue_valid) begin
        seen = 1;
        check_output("issue_slot", issue_slot, slot);
        check_output("issue_pos", {issue_x, issue_y, issue_z}, {m_x[slot], m_y[slot], m_z[slot]});
        check_output("issue_timer", {issue_timer_x, issue_timer_z}, {m_tx[slot], m_tz[slot]});
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
      end else begin
        tick();
      end
    end
    if (!seen) check_output("issue_seen", issue_valid, 1'b1);
  endtask

  task automatic do_return(input int slot, input logic solid, input logic oob,
                           input logic [2:0] face);
    logic term;
    ret_valid        = 1'b1;
    ret_slot         = 2'(slot);
    ret_solid        = solid;
    ret_oob          = oob;
    ret_face         = face;
    ret_next_x       = m_x[slot] + 5'(face[0]);
    ret_next_y       = m_y[slot] + 5'(face[1]);
    ret_next_z       = m_z[slot] + 5'(face[2]);
    ret_next_timer_x = m_tx[slot] + 32'h10;
    ret_next_timer_y = m_ty[slot] + 32'h20;
    ret_next_timer_z = m_tz[slot] + 32'h30;
    term = solid || oob || (m_steps[slot] >= m_max[slot]);
    if (term) begin
      exp_q.push_back(pack_res(m_tag[slot], solid, !solid && oob, !solid && !oob,
                               m_x[slot], m_y[slot], m_z[slot], m_face[slot], m_steps[slot]));
    end else begin
      m_x[slot]  = ret_next_x;  m_y[slot]  = ret_next_y;  m_z[slot]  = ret_next_z;
      m_tx[slot] = ret_next_timer_x;  m_ty[slot] = ret_next_timer_y;
      m_tz[slot] = ret_next_timer_z;  m_face[slot] = face;
      if (m_steps[slot] != 16'hFFFF) m_steps[slot] = m_steps[slot] + 16'd1;
    end
    tick();
    ret_valid = 1'b0;
    ret_solid = 1'b0;
    ret_oob   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    job_valid = 0; job_x = 0; job_y = 0; job_z = 0;
    job_timer_x = 0; job_timer_y = 0; job_timer_z = 0; job_max_steps = 0; job_tag = 0;
    issue_ready = 0; ret_valid = 0; ret_slot = 0; ret_solid = 0; ret_oob = 0;
    ret_next_x = 0; ret_next_y = 0; ret_next_z = 0;
    ret_next_timer_x = 0; ret_next_timer_y = 0; ret_next_timer_z = 0; ret_face = 0;
    res_ready = 1'b1;
    #1;
    check_output("rst_issue_valid", issue_valid, 1'b0);
    check_output("rst_res_valid", res_valid, 1'b0);
    check_output("rst_res_fields", dut_res(), 64'd0);
    check_output("rst_busy", busy_count, 3'd0);
    check_output("rst_perr", protocol_error, 1'b0);
    check_output("rst_job_ready", job_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] hit");
    apply_stimulus(0, 5'd1, 5'd2, 5'd3, 16'd10, 8'hA1);
    check_output("accept_issue_valid", issue_valid, 1'b1);
    wait_issue(0);
    do_return(0, 1'b0, 1'b0, 3'b001);
    wait_issue(0);
    do_return(0, 1'b0, 1'b0, 3'b001);
    wait_issue(0);
    do_return(0, 1'b1, 1'b0, 3'b000);
    check_output("hit_lat0", res_valid, 1'b0);
    tick();
    check_output("hit_lat1", res_valid, 1'b1);
    drain();
    check_output("hit_busy", busy_count, 3'd0);

    $display("[TB] timeout");
    apply_stimulus(0, 5'd4, 5'd4, 5'd4, 16'd2, 8'hB2);
    for (int r = 0; r < 3; r++) begin
      wait_issue(0);
      do_return(0, 1'b0, 1'b0, 3'b010);
    end
    drain();
    apply_stimulus(0, 5'd9, 5'd8, 5'd7, 16'd0, 8'hB3);
    wait_issue(0);
    do_return(0, 1'b0, 1'b0, 3'b100);
    drain();

    $display("[TB] full slots");
    nexp = 0;
    issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (issue_valid) begin
        check_output("rr_order", issue_slot, nexp);
        nexp++;
      end
      if (k < 4) begin
        job_valid = 1'b1;
        job_x = 5'(4 * k + 2); job_y = 5'(k + 10); job_z = 5'(k);
        job_timer_x = 32'(k); job_timer_y = 32'(k + 1); job_timer_z = 32'(k + 2);
        job_max_steps = 16'd10; job_tag = 8'(8'hC0 + k);
        m_x[k] = job_x; m_y[k] = job_y; m_z[k] = job_z;
        m_tx[k] = job_timer_x; m_ty[k] = job_timer_y; m_tz[k] = job_timer_z;
        m_max[k] = 16'd10; m_steps[k] = 0; m_tag[k] = job_tag; m_face[k] = 0;
      end else begin
        job_valid = 1'b0;
      end
      tick();
    end
    issue_ready = 1'b0;
    check_output("full_issues", nexp, 4);
    check_output("full_job_ready", job_ready, 1'b0);
    check_output("full_busy", busy_count, 3'd4);
    do_return(1, 1'b1, 1'b0, 3'b000);
    check_output("drain_jr0", job_ready, 1'b0);
    tick();
    check_output("drain_jr1", job_ready, 1'b1);
    drain();

    $display("[TB] out-of-order returns");
    apply_stimulus(1, 5'd20, 5'd21, 5'd22, 16'd10, 8'hD1);
    wait_issue(1);
    check_output("ooo_busy4", busy_count, 3'd4);
    do_return(2, 1'b0, 1'b0, 3'b001);
    do_return(0, 1'b0, 1'b1, 3'b001);
    do_return(3, 1'b0, 1'b0, 3'b010);
    do_return(1, 1'b0, 1'b0, 3'b100);
    wait_issue(2);
    wait_issue(3);
    wait_issue(1);
    drain();
    check_output("ooo_busy3", busy_count, 3'd3);

    $display("[TB] backpressure");
    res_ready = 1'b0;
    do_return(1, 1'b1, 1'b0, 3'b000);
    do_return(2, 1'b1, 1'b0, 3'b000);
    do_return(3, 1'b0, 1'b1, 3'b000);
    check_output("bp_valid_held", res_valid, 1'b1);
    snap = dut_res();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("bp_hold", dut_res(), snap);
    end
    check_output("bp_first_tag", res_tag, m_tag[1]);
    res_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      check_output("bp_stream_valid", res_valid, 1'b1);
      check_output("bp_stream_tag", res_tag, m_tag[k]);
      tick();
    end
    check_output("bp_empty", res_valid, 1'b0);

    $display("[TB] protocol error");
    ret_valid = 1'b1; ret_slot = 2'd2; ret_solid = 1'b1;
    tick();
    ret_valid = 1'b0; ret_solid = 1'b0;
    tick();
    check_output("perr_set", protocol_error, 1'b1);
    check_output("perr_busy", busy_count, 3'd0);
    check_output("perr_res", res_valid, 1'b0);
    check_output("perr_jr", job_ready, 1'b1);
    tick();
    tick();
    check_output("perr_sticky", protocol_error, 1'b1);

    $display("[TB] reset mid-run");
    apply_stimulus(0, 5'd7, 5'd7, 5'd7, 16'd5, 8'hE1);
    wait_issue(0);
    res_ready = 1'b0;
    do_return(0, 1'b1, 1'b0, 3'b000);
    tick();
    tick();
    check_output("pre_rst_valid", res_valid, 1'b1);
    apply_stimulus(0, 5'd8, 5'd8, 5'd8, 16'd5, 8'hE2);
    check_output("pre_rst_busy", busy_count, 3'd1);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_issue", issue_valid, 1'b0);
    check_output("mid_rst_res_valid", res_valid, 1'b0);
    check_output("mid_rst_res_fields", dut_res(), 64'd0);
    check_output("mid_rst_busy", busy_count, 3'd0);
    check_output("mid_rst_perr", protocol_error, 1'b0);
    check_output("mid_rst_jr", job_ready, 1'b1);
    exp_q.delete();
    @(negedge clock);
    reset_n   = 1'b1;
    res_ready = 1'b1;
    ret_valid = 1'b1; ret_slot = 2'd0;
    tick();
    ret_valid = 1'b0;
    check_output("post_rst_stray", protocol_error, 1'b1);
    apply_stimulus(0, 5'd1, 5'd1, 5'd1, 16'd0, 8'hF0);
    wait_issue(0);
    do_return(0, 1'b0, 1'b0, 3'b100);
    drain();
    check_output("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
